// File: rtl/pe_buffer_manager_if.sv
// Job control, task/result streams and PE-facing buffer ports of the buffer manager.
// slave = buffer manager side, master = host/PE side driving the manager's inputs.
interface pe_buffer_manager_if #(
  parameter int TBB_DATA_WIDTH = 32,
  parameter int TBB_ADDR_WIDTH = 16,
  parameter int RBB_DATA_WIDTH = 512,
  parameter int RBB_ADDR_WIDTH = 8
);
  logic                      job_start;
  logic                      job_busy;
  logic                      job_done;
  logic                      job_error;
  logic                      in_valid;
  logic                      in_ready;
  logic [TBB_DATA_WIDTH-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [RBB_DATA_WIDTH-1:0] out_data;
  logic                      out_last;
  logic                      bm2pe_start;
  logic                      pe2bm_done;
  logic                      pe2bm_rbbWrEn;
  logic [RBB_ADDR_WIDTH-1:0] pe2bm_rbbWrAddr;
  logic [RBB_DATA_WIDTH-1:0] pe2bm_rbbWrDin;
  logic [TBB_ADDR_WIDTH-1:0] pe2bm_tbbRdAddr;
  logic [TBB_DATA_WIDTH-1:0] bm2pe_tbbRdDout;

  modport slave (
    input  job_start, in_valid, in_data, out_ready,
    input  pe2bm_done, pe2bm_rbbWrEn, pe2bm_rbbWrAddr, pe2bm_rbbWrDin, pe2bm_tbbRdAddr,
    output job_busy, job_done, job_error, in_ready, out_valid, out_data, out_last,
    output bm2pe_start, bm2pe_tbbRdDout
  );

  modport master (
    output job_start, in_valid, in_data, out_ready,
    output pe2bm_done, pe2bm_rbbWrEn, pe2bm_rbbWrAddr, pe2bm_rbbWrDin, pe2bm_tbbRdAddr,
    input  job_busy, job_done, job_error, in_ready, out_valid, out_data, out_last,
    input  bm2pe_start, bm2pe_tbbRdDout
  );
endinterface

// File: rtl/pe_buffer_manager.sv
// Buffer manager for one PE: fill TBB, start PE, capture RBB, drain RBB (2-cycle first-word latency).
// Result stream is valid/ready; a 2-entry FIFO plus read credits keeps full rate without drops.
module pe_bm_fifo #(
  parameter int W  = 8,
  parameter int AW = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  input  logic          pop_rdy,
  output logic          pop_vld,
  output logic [W-1:0]  pop_dat,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign pop_vld = (count != '0);
  assign pop     = pop_vld && pop_rdy;
  assign push    = push_vld && (count != {1'b1, {AW{1'b0}}});
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end
endmodule

module pe_buffer_manager #(
  parameter int TBB_DATA_WIDTH = 32,
  parameter int TBB_ADDR_WIDTH = 16,
  parameter int RBB_DATA_WIDTH = 512,
  parameter int RBB_ADDR_WIDTH = 8,
  parameter int PE_TIMEOUT     = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  pe_buffer_manager_if.slave bm
);
  typedef enum logic [2:0] {IDLE, FILL, START, WAIT_PE, DRAIN, DONE} state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [TBB_DATA_WIDTH-1:0] tbb_mem [2**TBB_ADDR_WIDTH];
  logic [RBB_DATA_WIDTH-1:0] rbb_mem [2**RBB_ADDR_WIDTH];
  logic [TBB_ADDR_WIDTH-1:0] fill_cnt;
  logic [31:0]               tmo_cnt;
  logic [RBB_ADDR_WIDTH-1:0] rd_addr;
  logic                      rd_issued_all;
  logic                      rd_vld_q;
  logic                      rd_last_q;
  logic [RBB_DATA_WIDTH-1:0] rd_dat_q;
  logic [TBB_DATA_WIDTH-1:0] tbb_rd_q;
  logic                      job_error_q;
  logic                      job_accept;
  logic                      err_set;
  logic                      fill_fire;
  logic                      rbb_wr;
  logic                      rd_issue;
  logic [2:0]                occ;
  logic                      fifo_vld;
  logic [RBB_DATA_WIDTH:0]   fifo_dat;
  logic [1:0]                fifo_cnt;
  logic                      out_fire;

  assign fill_fire = reset_n && (state == FILL) && bm.in_valid;
  assign rbb_wr    = reset_n && bm.pe2bm_rbbWrEn && ((state == START) || (state == WAIT_PE));
  assign out_fire  = fifo_vld && bm.out_ready;

  // Occupancy counts FIFO entries plus the read in flight, so a read issues only if it will fit.
  assign occ      = {1'b0, fifo_cnt} + {2'b0, rd_vld_q} - {2'b0, out_fire};
  assign rd_issue = (state == DRAIN) && !rd_issued_all && (occ < 3'd2);

  always_comb begin
    state_nxt  = state;
    job_accept = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (bm.job_start) begin
          job_accept = 1'b1;
          state_nxt  = FILL;
        end
      end
      FILL:    if (fill_fire && (fill_cnt == '1)) state_nxt = START;
      START:   state_nxt = WAIT_PE;
      WAIT_PE: begin
        if (bm.pe2bm_done) begin
          state_nxt = DRAIN;
        end else if ((PE_TIMEOUT != 0) && (tmo_cnt == 32'(PE_TIMEOUT - 1))) begin
          err_set   = 1'b1;
          state_nxt = DONE;
        end
      end
      DRAIN:   if (out_fire && fifo_dat[RBB_DATA_WIDTH]) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      fill_cnt      <= '0;
      tmo_cnt       <= '0;
      rd_addr       <= '0;
      rd_issued_all <= 1'b0;
      rd_vld_q      <= 1'b0;
      rd_last_q     <= 1'b0;
      job_error_q   <= 1'b0;
      tbb_rd_q      <= '0;
    end else begin
      state <= state_nxt;
      if (job_accept) begin
        fill_cnt      <= '0;
        rd_addr       <= '0;
        rd_issued_all <= 1'b0;
        job_error_q   <= 1'b0;
      end else if (fill_fire) begin
        fill_cnt <= fill_cnt + 1'b1;
      end
      if (state == START)        tmo_cnt <= '0;
      else if (state == WAIT_PE) tmo_cnt <= tmo_cnt + 32'd1;
      if (err_set) job_error_q <= 1'b1;
      if (rd_issue) begin
        rd_addr <= rd_addr + 1'b1;
        if (rd_addr == '1) rd_issued_all <= 1'b1;
      end
      rd_vld_q  <= rd_issue;
      rd_last_q <= rd_issue && (rd_addr == '1);
      tbb_rd_q  <= tbb_mem[bm.pe2bm_tbbRdAddr];
    end
  end

  // Buffer RAMs are never cleared; reads return pre-write contents on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (fill_fire) tbb_mem[fill_cnt] <= bm.in_data;
    if (rbb_wr)    rbb_mem[bm.pe2bm_rbbWrAddr] <= bm.pe2bm_rbbWrDin;
    if (rd_issue)  rd_dat_q <= rbb_mem[rd_addr];
  end

  pe_bm_fifo #(
    .W  (RBB_DATA_WIDTH + 1),
    .AW (1)
  ) u_out_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (rd_vld_q),
    .push_dat ({rd_last_q, rd_dat_q}),
    .pop_rdy  (bm.out_ready),
    .pop_vld  (fifo_vld),
    .pop_dat  (fifo_dat),
    .count    (fifo_cnt)
  );

  assign bm.job_busy        = (state != IDLE);
  assign bm.job_done        = (state == DONE);
  assign bm.job_error       = job_error_q;
  assign bm.in_ready        = (state == FILL);
  assign bm.bm2pe_start     = (state == START);
  assign bm.bm2pe_tbbRdDout = tbb_rd_q;
  assign bm.out_valid       = fifo_vld;
  assign bm.out_data        = fifo_vld ? fifo_dat[RBB_DATA_WIDTH-1:0] : '0;
  assign bm.out_last        = fifo_vld && fifo_dat[RBB_DATA_WIDTH];
endmodule

// File: tb/tb_pe_buffer_manager.sv
// Bench for pe_buffer_manager: table-driven jobs, randomized jobs against an array model, timeout.
module tb_pe_buffer_manager;
  localparam int TDW = 32;
  localparam int TAW = 4;
  localparam int RDW = 64;
  localparam int RAW = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pe_buffer_manager_if #(.TBB_DATA_WIDTH(TDW), .TBB_ADDR_WIDTH(TAW),
                         .RBB_DATA_WIDTH(RDW), .RBB_ADDR_WIDTH(RAW)) bm ();
  pe_buffer_manager_if #(.TBB_DATA_WIDTH(TDW), .TBB_ADDR_WIDTH(TAW),
                         .RBB_DATA_WIDTH(RDW), .RBB_ADDR_WIDTH(RAW)) bt ();

  pe_buffer_manager #(.TBB_DATA_WIDTH(TDW), .TBB_ADDR_WIDTH(TAW), .RBB_DATA_WIDTH(RDW),
                      .RBB_ADDR_WIDTH(RAW), .PE_TIMEOUT(0)) dut (
    .clk(clk), .reset_n(reset_n), .bm(bm));
  pe_buffer_manager #(.TBB_DATA_WIDTH(TDW), .TBB_ADDR_WIDTH(TAW), .RBB_DATA_WIDTH(RDW),
                      .RBB_ADDR_WIDTH(RAW), .PE_TIMEOUT(20)) dut_tmo (
    .clk(clk), .reset_n(reset_n), .bm(bt));

  typedef struct packed {
    logic [31:0]      in_base;
    logic [7:0]       vpat;
    logic [3:0]       vlen;
    logic [7:0]       rpat;
    logic [3:0]       rlen;
    logic [3:0]       abort_after;
    logic [63:0]      wr_base;
    logic [3:0][63:0] exp_w;
  } vec_t;

  int n_checks = 0;
  int n_err = 0;

  // Reference state: what each buffer entry should hold, independent of the DUT's timing.
  logic [TDW-1:0] tbb_model [16];
  bit             tbb_known [16];
  logic [RDW-1:0] rbb_model [4];
  logic [TDW-1:0] tw [16];
  int             nwr;
  logic [RAW-1:0] wa [8];
  logic [RDW-1:0] wv [8];
  logic [RDW-1:0] exp_w [4];
  vec_t           vecs [5];

  task automatic chk_w(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk_w({nm, "_ctl"}, 64'({bm.job_busy, bm.job_done, bm.job_error, bm.in_ready, bm.out_valid,
                              bm.out_last, bm.bm2pe_start}), 64'd0);
    chk_w({nm, "_odat"}, bm.out_data, 64'd0);
    chk_w({nm, "_rdout"}, 64'(bm.bm2pe_tbbRdDout), 64'd0);
  endtask

  task automatic run_job(input logic [7:0] vpat, input int vlen, input logic [7:0] rpat,
                         input int rlen, input int abort_after, input bit noisy);
    int acc, cyc, nout, k, first_cyc, last_cyc, limit;
    logic [TDW-1:0] exp_rd;
    bit exp_rd_ok, start_early, stalled, seen;
    logic [RDW-1:0] prev_dat;
    logic prev_last;

    @(negedge clk);
    chk_i("idle_busy", int'(bm.job_busy), 0);
    bm.job_start = 1'b1;
    @(negedge clk);
    bm.job_start = 1'b0;
    chk_i("accept_busy", int'(bm.job_busy), 1);
    chk_i("accept_err_clear", int'(bm.job_error), 0);
    chk_i("fill_in_ready", int'(bm.in_ready), 1);

    acc = 0; cyc = 0; start_early = 0; exp_rd_ok = 0; exp_rd = '0;
    while (acc < 16 && cyc < 400) begin
      if (bm.bm2pe_start) start_early = 1;
      if (exp_rd_ok) chk_w("tbb_rd_fill", 64'(bm.bm2pe_tbbRdDout), 64'(exp_rd));
      bm.pe2bm_tbbRdAddr = TAW'(acc);
      exp_rd_ok = tbb_known[acc];
      exp_rd = tbb_model[acc];
      bm.in_valid = vpat[3'(cyc % vlen)];
      bm.in_data = tw[acc];
      bm.job_start = noisy && (cyc == 3);
      bm.pe2bm_rbbWrEn = noisy && (cyc == 2);
      bm.pe2bm_rbbWrAddr = RAW'($urandom);
      bm.pe2bm_rbbWrDin = '1;
      bm.pe2bm_done = noisy && (cyc == 4);
      if (bm.in_valid && bm.in_ready) begin
        tbb_model[acc] = tw[acc];
        tbb_known[acc] = 1;
        acc++;
      end
      cyc++;
      @(negedge clk);
    end
    bm.in_valid = 0; bm.job_start = 0; bm.pe2bm_rbbWrEn = 0; bm.pe2bm_done = 0;
    chk_i("fill_accepts", acc, 16);
    chk_i("start_not_early", int'(start_early), 0);
    chk_i("start_after_fill", int'(bm.bm2pe_start), 1);
    if (exp_rd_ok) chk_w("tbb_rd_fill", 64'(bm.bm2pe_tbbRdDout), 64'(exp_rd));

    for (int a = 0; a <= 16; a++) begin
      if (a > 0) chk_w("tbb_rd_pe", 64'(bm.bm2pe_tbbRdDout), 64'(tbb_model[a-1]));
      if (a == 1) chk_i("start_one_cycle", int'(bm.bm2pe_start), 0);
      if (a < 16) bm.pe2bm_tbbRdAddr = TAW'(a);
      bm.job_start = noisy && (a == 5);
      @(negedge clk);
    end
    bm.job_start = 0;
    chk_i("wait_busy", int'(bm.job_busy), 1);

    if (nwr == 0) begin
      bm.pe2bm_done = 1;
      @(negedge clk);
    end
    for (int i = 0; i < nwr; i++) begin
      bm.pe2bm_rbbWrEn = 1;
      bm.pe2bm_rbbWrAddr = wa[i];
      bm.pe2bm_rbbWrDin = wv[i];
      bm.pe2bm_done = (i == nwr - 1);
      @(negedge clk);
    end
    bm.pe2bm_rbbWrEn = 0; bm.pe2bm_done = 0;

    limit = (abort_after != 0) ? abort_after : 4;
    nout = 0; k = 0; cyc = 0; seen = 0; stalled = 0; first_cyc = 0; last_cyc = 0;
    prev_dat = '0; prev_last = 0;
    while (nout < limit && cyc < 100) begin
      if (stalled) begin
        chk_i("hold_valid", int'(bm.out_valid), 1);
        chk_w("hold_data", bm.out_data, prev_dat);
        chk_i("hold_last", int'(bm.out_last), int'(prev_last));
      end
      if (bm.out_valid && !seen) begin
        seen = 1;
        chk_i("valid_latency_ok", int'(cyc <= 2), 1);
      end
      bm.out_ready = seen ? rpat[3'(k % rlen)] : 1'b0;
      if (seen) k++;
      if (bm.out_valid && bm.out_ready) begin
        chk_w("out_data", bm.out_data, exp_w[nout]);
        chk_i("out_last", int'(bm.out_last), int'(nout == 3));
        if (nout == 0) first_cyc = cyc;
        last_cyc = cyc;
        nout++;
      end
      stalled = bm.out_valid && !bm.out_ready;
      prev_dat = bm.out_data;
      prev_last = bm.out_last;
      cyc++;
      @(negedge clk);
    end
    bm.out_ready = 0;
    chk_i("drain_count", nout, limit);

    if (abort_after != 0) begin
      reset_n = 0;
      @(negedge clk);
      chk_outputs_zero("abort_reset");
      reset_n = 1;
      @(negedge clk);
      chk_i("abort_idle", int'(bm.job_busy), 0);
      chk_i("abort_no_done", int'(bm.job_done), 0);
      return;
    end

    if (rlen == 1 && rpat[0]) chk_i("full_rate_span", last_cyc - first_cyc, 3);
    chk_i("done_pulse", int'(bm.job_done), 1);
    chk_i("done_no_err", int'(bm.job_error), 0);
    chk_i("done_no_valid", int'(bm.out_valid), 0);
    @(negedge clk);
    chk_i("done_one_cycle", int'(bm.job_done), 0);
    chk_i("back_idle", int'(bm.job_busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, cnt, vlen, rlen;
    bit saw_valid;
    logic [7:0] vpat, rpat;

    bm.job_start = 0; bm.in_valid = 0; bm.in_data = '0; bm.out_ready = 0;
    bm.pe2bm_done = 0; bm.pe2bm_rbbWrEn = 0; bm.pe2bm_rbbWrAddr = '0;
    bm.pe2bm_rbbWrDin = '0; bm.pe2bm_tbbRdAddr = '0;
    bt.job_start = 0; bt.in_valid = 0; bt.in_data = '0; bt.out_ready = 0;
    bt.pe2bm_done = 0; bt.pe2bm_rbbWrEn = 0; bt.pe2bm_rbbWrAddr = '0;
    bt.pe2bm_rbbWrDin = '0; bt.pe2bm_tbbRdAddr = '0;
    for (int i = 0; i < 16; i++) tbb_known[i] = 0;

    reset_n = 0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    reset_n = 1;

    vecs[0] = '{in_base: 32'h100, vpat: 8'h01, vlen: 4'd1, rpat: 8'h01, rlen: 4'd1,
                abort_after: 4'd0, wr_base: 64'h0, exp_w: {64'd3, 64'd2, 64'd1, 64'd0}};
    vecs[1] = '{in_base: 32'h200, vpat: 8'h01, vlen: 4'd1, rpat: 8'h69, rlen: 4'd7,
                abort_after: 4'd0, wr_base: 64'h0, exp_w: {64'd3, 64'd2, 64'd1, 64'd0}};
    vecs[2] = '{in_base: 32'h300, vpat: 8'h02, vlen: 4'd2, rpat: 8'h01, rlen: 4'd1,
                abort_after: 4'd0, wr_base: 64'hA0,
                exp_w: {64'hA3, 64'hA2, 64'hA1, 64'hA0}};
    vecs[3] = '{in_base: 32'h400, vpat: 8'h01, vlen: 4'd1, rpat: 8'h01, rlen: 4'd1,
                abort_after: 4'd2, wr_base: 64'h50,
                exp_w: {64'h53, 64'h52, 64'h51, 64'h50}};
    vecs[4] = vecs[0];

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 16; i++) tw[i] = vecs[r].in_base + 32'(i);
      nwr = 4;
      for (int i = 0; i < 4; i++) begin
        wa[i] = RAW'(i);
        wv[i] = vecs[r].wr_base + 64'(i);
        rbb_model[i] = wv[i];
        exp_w[i] = vecs[r].exp_w[i];
      end
      run_job(vecs[r].vpat, int'(vecs[r].vlen), vecs[r].rpat, int'(vecs[r].rlen),
              int'(vecs[r].abort_after), 1'b0);
    end

    // Randomized jobs: partial RBB writes expose stale or illegal writes through later drains.
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      bm.pe2bm_rbbWrEn = 1;
      bm.pe2bm_rbbWrAddr = RAW'($urandom);
      bm.pe2bm_rbbWrDin = 64'hFF;
      bm.pe2bm_done = 1;
      @(negedge clk);
      bm.pe2bm_rbbWrEn = 0; bm.pe2bm_done = 0;
      chk_i("idle_noise_no_busy", int'(bm.job_busy), 0);

      for (int i = 0; i < 16; i++) tw[i] = $urandom;
      vlen = int'($urandom_range(1, 8));
      vpat = 8'($urandom);
      vpat[3'(vlen - 1)] = 1'b1;
      rlen = int'($urandom_range(1, 8));
      rpat = 8'($urandom);
      rpat[3'(rlen - 1)] = 1'b1;
      nwr = int'($urandom_range(0, 5));
      for (int i = 0; i < nwr; i++) begin
        wa[i] = RAW'($urandom);
        wv[i] = {$urandom, $urandom};
        rbb_model[wa[i]] = wv[i];
      end
      for (int i = 0; i < 4; i++) exp_w[i] = rbb_model[i];
      run_job(vpat, vlen, rpat, rlen, 0, 1'b1);
    end

    // Timeout instance: PE never finishes.
    @(negedge clk);
    bt.job_start = 1;
    @(negedge clk);
    bt.job_start = 0;
    acc = 0;
    for (int c = 0; c < 100 && acc < 16; c++) begin
      bt.in_valid = 1;
      bt.in_data = 32'(c);
      if (bt.in_ready) acc++;
      @(negedge clk);
    end
    bt.in_valid = 0;
    chk_i("tmo_start", int'(bt.bm2pe_start), 1);
    cnt = 0; saw_valid = 0;
    while (!bt.job_done && cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (bt.out_valid) saw_valid = 1;
    end
    chk_i("tmo_cycles", cnt, 21);
    chk_i("tmo_error", int'(bt.job_error), 1);
    chk_i("tmo_no_valid", int'(saw_valid), 0);
    @(negedge clk);
    chk_i("tmo_done_one_cycle", int'(bt.job_done), 0);
    chk_i("tmo_error_held", int'(bt.job_error), 1);
    chk_i("tmo_idle", int'(bt.job_busy), 0);
    bt.job_start = 1;
    @(negedge clk);
    bt.job_start = 0;
    chk_i("tmo_error_cleared", int'(bt.job_error), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
